ifu32: RTL and testbench
========================

# ifu32

Instruction fetch unit for the 32-bit RV core. Sits directly upstream of the decode stage and feeds it one instruction word at a time. It owns the PC, issues single-outstanding requests to instruction memory, buffers one fetched word behind a valid/ready handshake, and accepts PC redirects from the execute/branch stage. Redirects kill any in-flight fetch.

## Interface
- `WIDTH`, 32 — address/data width.
- `RESET_PC`, 32'h8000_0000 — PC value loaded on reset.

Ports:
- `clk` in 1 — the single clock.
- `rst` in 1 — reset; synchronous, active-high.
- `imem_req_valid` out 1 — fetch request valid.
- `imem_req_ready` in 1 — memory accepts request.
- `imem_addr` out WIDTH — fetch address.
- `imem_resp_valid` in 1 — response data valid (exactly one per accepted request).
- `imem_resp_data` in 32 — fetched instruction word.
- `imem_resp_err` in 1 — bus/access error on this response.
- `redirect_valid` in 1 — PC redirect (branch/jump/trap).
- `redirect_pc` in WIDTH — redirect target.
- `inst_valid` out 1 — instruction available to decode.
- `inst_ready` in 1 — decode accepts instruction.
- `inst` out 32 — instruction word, to decode `inst`.
- `inst_pc` out WIDTH — PC of `inst`.
- `inst_fault` out 1 — instruction is a fetch fault; `inst` is 0.

## Operation
- Registers:
  - `pc` (WIDTH)
  - `kill` (1)
  - output buffer (`inst`, `inst_pc`, `inst_fault`)
  - state (IDLE, REQ, WAIT, HOLD)
- Reset values:
  - state IDLE; `pc`=RESET_PC; `kill`=0.
  - `inst`=0, `inst_pc`=0, `inst_fault`=0.
  - `inst_valid`=0, `imem_req_valid`=0, `imem_addr`=RESET_PC.
- Output decoding:
  - `imem_req_valid` = (state==REQ) and not misaligned-skip.
  - `imem_addr` = `pc`.
  - `inst_valid` = (state==HOLD).
- IDLE: go to REQ next cycle unconditionally.
- REQ: hold request until `imem_req_ready`, then go to WAIT. Address must stay stable while valid and not ready.
- WAIT: on `imem_resp_valid`:
  - If `kill`=1: discard the response, clear `kill`, go to REQ.
  - Otherwise: buffer gets `inst`=`imem_resp_data` (0 if err), `inst_pc`=`pc`, `inst_fault`=`imem_resp_err`; `pc` becomes `pc`+4 (mod 2^WIDTH, wraps to 0 silently); go to HOLD.
- HOLD: on `inst_ready`, go to REQ.
- Redirect has highest priority in every state:
  - `pc` becomes `redirect_pc`.
  - IDLE/REQ without acceptance/HOLD: go to REQ.
  - REQ with `imem_req_ready` in the same cycle: request is outstanding; go to WAIT with `kill`=1.
  - WAIT without response: stay in WAIT with `kill`=1.
  - WAIT with `imem_resp_valid` in the same cycle: response dropped; go to REQ with `kill`=0.
  - HOLD with `inst_ready` in the same cycle: the handshake completes (decode keeps the word); go to REQ.
  - Back-to-back redirects: the last one wins.
- Errors never stall. A faulted word is delivered like any other; the downstream trap logic redirects.

## Timing
- Zero-wait memory (ready=1, response the cycle after acceptance): REQ, then WAIT, then HOLD. First `inst_valid` is 3 cycles after `rst` deasserts. Throughput is one instruction per 3 cycles with `inst_ready`=1.
- Memory latency L cycles adds L-1 WAIT cycles.
- Redirect to new-target `imem_req_valid`: 1 cycle if no fetch is outstanding. With an outstanding fetch, 1 cycle after the stale response arrives.
- `inst_valid` drops the cycle after a redirect.
- `rst` asserted mid-fetch: all state reinitialises next edge. A response for the abandoned request arriving after reset must be ignored; it is ignored because state is IDLE/REQ, not WAIT.
- `inst`/`inst_pc`/`inst_fault` are stable while `inst_valid`=1 and `inst_ready`=0.

## Configuration
- `IFU32_MISALIGN_TRAP_EN` defined:
  - In REQ, if `pc`[1:0]≠0, no memory request is issued.
  - Next cycle, go to HOLD with `inst`=0, `inst_fault`=1, `inst_pc`=`pc`; `pc` is unchanged.
  - Decode/trap logic must redirect away.
- Not defined: `pc`[1:0] is forced to 0 on reset and redirect load; fetch always aligned; no misalign fault.

## Test plan
- Reset, zero-wait memory returning 32'h0000_0013, `inst_ready`=1 → `inst_valid` pulses at cycles 3,6,9 with `inst_pc` 8000_0000, 8000_0004, 8000_0008; `inst_fault`=0.
- Memory ready held low 5 cycles, then `inst_ready`=0 for 4 cycles in HOLD → `imem_addr` stable throughout; no second request; `inst` stable; `inst_valid` stays 1.
- Redirect to 8000_0100 in WAIT, response arrives 2 cycles later with 32'hDEAD_BEEF → word never appears; next request addr 8000_0100; delivered `inst_pc`=8000_0100.
- Redirect coincident with `imem_resp_valid` → response dropped, `kill`=0, next `imem_addr`=`redirect_pc`.
- `imem_resp_err`=1 at pc 8000_0008 → `inst`=0, `inst_fault`=1, `inst_pc`=8000_0008, next fetch 8000_000C.
- Redirect to 8000_0102: with macro → no memory request, fault delivered with `inst_pc`=8000_0102. Without macro → `imem_addr`=8000_0100, no fault.

Source files
------------

// File: rtl/ifu32.sv
// ifu32 - instruction fetch unit for the 32-bit RV core.
//
// Owns the PC, issues one outstanding instruction-memory request at a time,
// buffers one fetched word towards decode behind a valid/ready handshake and
// accepts PC redirects from execute. A redirect that lands while a fetch is
// outstanding sets `kill`, so the stale response is dropped when it arrives.
//
// Build option: IFU32_MISALIGN_TRAP_EN
//   defined   - a PC with [1:0] != 0 issues no memory request; a fetch fault
//               word (inst=0, inst_fault=1) is delivered instead.
//   undefined - PC bits [1:0] are forced to zero on reset and redirect load,
//               so every fetch is word aligned and no misalign fault exists.

module ifu32 #(
  parameter int               WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(32'h8000_0000)
) (
  input  logic             clk,
  input  logic             rst,
  // instruction memory request channel
  output logic             imem_req_valid,
  input  logic             imem_req_ready,
  output logic [WIDTH-1:0] imem_addr,
  // instruction memory response channel
  input  logic             imem_resp_valid,
  input  logic [31:0]      imem_resp_data,
  input  logic             imem_resp_err,
  // redirect from execute / branch / trap
  input  logic             redirect_valid,
  input  logic [WIDTH-1:0] redirect_pc,
  // instruction towards decode
  output logic             inst_valid,
  input  logic             inst_ready,
  output logic [31:0]      inst,
  output logic [WIDTH-1:0] inst_pc,
  output logic             inst_fault
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_HOLD = 2'd3
  } state_t;

  localparam logic [WIDTH-1:0] PC_STEP = WIDTH'(4);

  // Keeps a PC word aligned unless misaligned PCs are trapped instead.
  function automatic logic [WIDTH-1:0] align_pc(input logic [WIDTH-1:0] addr);
`ifdef IFU32_MISALIGN_TRAP_EN
    return addr;
`else
    return {addr[WIDTH-1:2], 2'b00};
`endif
  endfunction

  state_t           state_r;
  state_t           state_s;
  logic [WIDTH-1:0] pc_r;
  logic [WIDTH-1:0] pc_s;
  logic             kill_r;
  logic             kill_s;
  logic [31:0]      inst_r;
  logic [31:0]      inst_s;
  logic [WIDTH-1:0] inst_pc_r;
  logic [WIDTH-1:0] inst_pc_s;
  logic             inst_fault_r;
  logic             inst_fault_s;

  logic             misalign_s;
  logic             req_valid_s;
  logic             req_fire_s;

`ifdef IFU32_MISALIGN_TRAP_EN
  assign misalign_s = (pc_r[1:0] != 2'b00);
`else
  assign misalign_s = 1'b0;
`endif

  // A misaligned PC never reaches the memory bus; it becomes a fault word.
  assign req_valid_s = (state_r == S_REQ) && !misalign_s;
  assign req_fire_s  = req_valid_s && imem_req_ready;

  // Next-state, next-PC, kill and output-buffer decisions; redirect wins.
  always_comb begin
    state_s      = state_r;
    pc_s         = pc_r;
    kill_s       = kill_r;
    inst_s       = inst_r;
    inst_pc_s    = inst_pc_r;
    inst_fault_s = inst_fault_r;

    if (redirect_valid) begin
      pc_s = align_pc(redirect_pc);
      case (state_r)
        S_REQ: begin
          if (req_fire_s) begin
            // request went out this cycle: its response is now stale
            state_s = S_WAIT;
            kill_s  = 1'b1;
          end else begin
            state_s = S_REQ;
          end
        end
        S_WAIT: begin
          if (imem_resp_valid) begin
            // stale response arrives together with the redirect: drop it
            state_s = S_REQ;
            kill_s  = 1'b0;
          end else begin
            state_s = S_WAIT;
            kill_s  = 1'b1;
          end
        end
        S_IDLE: begin
          state_s = S_REQ;
        end
        S_HOLD: begin
          // a coincident inst_ready still completes; the word is simply gone
          state_s = S_REQ;
        end
        default: begin
          state_s = S_IDLE;
        end
      endcase
    end else begin
      case (state_r)
        S_IDLE: begin
          state_s = S_REQ;
        end
        S_REQ: begin
          if (misalign_s) begin
            // PC is left alone; trap logic is expected to redirect away
            state_s      = S_HOLD;
            inst_s       = 32'h0000_0000;
            inst_pc_s    = pc_r;
            inst_fault_s = 1'b1;
          end else if (imem_req_ready) begin
            state_s = S_WAIT;
          end else begin
            state_s = S_REQ;
          end
        end
        S_WAIT: begin
          if (imem_resp_valid) begin
            if (kill_r) begin
              state_s = S_REQ;
              kill_s  = 1'b0;
            end else begin
              // faulted words are delivered as zero and never stall
              state_s      = S_HOLD;
              inst_s       = imem_resp_err ? 32'h0000_0000 : imem_resp_data;
              inst_pc_s    = pc_r;
              inst_fault_s = imem_resp_err;
              pc_s         = pc_r + PC_STEP;
            end
          end else begin
            state_s = S_WAIT;
          end
        end
        S_HOLD: begin
          if (inst_ready) begin
            state_s = S_REQ;
          end else begin
            state_s = S_HOLD;
          end
        end
        default: begin
          state_s = S_IDLE;
        end
      endcase
    end
  end

  // State, PC, kill flag and decode buffer registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= S_IDLE;
      pc_r         <= align_pc(RESET_PC);
      kill_r       <= 1'b0;
      inst_r       <= 32'h0000_0000;
      inst_pc_r    <= '0;
      inst_fault_r <= 1'b0;
    end else begin
      state_r      <= state_s;
      pc_r         <= pc_s;
      kill_r       <= kill_s;
      inst_r       <= inst_s;
      inst_pc_r    <= inst_pc_s;
      inst_fault_r <= inst_fault_s;
    end
  end

  // All outputs are decoded from registered state only.
  assign imem_req_valid = req_valid_s;
  assign imem_addr      = pc_r;
  assign inst_valid     = (state_r == S_HOLD);
  assign inst           = inst_r;
  assign inst_pc        = inst_pc_r;
  assign inst_fault     = inst_fault_r;

endmodule

// File: tb/tb_ifu32.sv
// tb_ifu32 - table-driven directed bench for ifu32.
// Each table row lists the outputs expected in one cycle (sampled at the
// falling edge) and the inputs driven for that cycle. A hand-written
// sequence afterwards covers a 3-cycle memory latency.

module tb_ifu32;

  logic        clk;
  logic        rst;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        imem_resp_err;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_fault;

  ifu32 #(.WIDTH(32), .RESET_PC(32'h8000_0000)) dut (
    .clk             (clk),
    .rst             (rst),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_addr       (imem_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .imem_resp_err   (imem_resp_err),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .inst_valid      (inst_valid),
    .inst_ready      (inst_ready),
    .inst            (inst),
    .inst_pc         (inst_pc),
    .inst_fault      (inst_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        chk;
    logic        qv;
    logic [31:0] addr;
    logic        iv;
    logic [31:0] bi;
    logic [31:0] bp;
    logic        bf;
    logic        r;
    logic        rdy;
    logic        rv;
    logic [31:0] rd;
    logic        re;
    logic        xv;
    logic [31:0] xpc;
    logic        ir;
  } vec_t;

  vec_t        vecs[$];
  logic [31:0] bi;
  logic [31:0] bp;
  logic        bf;
  int          passed;
  int          total;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end else begin
      passed++;
    end
  endtask

  // add(chk, exp req_valid, exp addr, exp inst_valid, rst, req_ready,
  //     resp_valid, resp_data, resp_err, redirect_valid, redirect_pc, inst_ready)
  task automatic add(input logic c, input logic qv, input logic [31:0] a, input logic iv,
                     input logic r, input logic rdy, input logic rv, input logic [31:0] rd,
                     input logic re, input logic xv, input logic [31:0] xpc, input logic ir);
    vec_t v;
    v.chk = c;  v.qv = qv; v.addr = a;  v.iv = iv;
    v.bi = bi;  v.bp = bp; v.bf = bf;
    v.r = r;    v.rdy = rdy; v.rv = rv; v.rd = rd; v.re = re;
    v.xv = xv;  v.xpc = xpc; v.ir = ir;
    vecs.push_back(v);
  endtask

  initial begin
    passed = 0;
    total  = 0;
    rst = 1'b1; imem_req_ready = 1'b0; imem_resp_valid = 1'b0;
    imem_resp_data = 32'h0; imem_resp_err = 1'b0;
    redirect_valid = 1'b0; redirect_pc = 32'h0; inst_ready = 1'b0;
    bi = 32'h0; bp = 32'h0; bf = 1'b0;

    // reset, then zero-wait fetches of 0x13 with decode always ready
    add(0,0,32'h0,0,                1,0,0,32'h0,0,0,32'h0,0);
    add(1,0,32'h8000_0000,0,        0,1,0,32'h0,0,0,32'h0,1);
    add(1,1,32'h8000_0000,0,        0,1,0,32'h0,0,0,32'h0,1);
    add(1,0,32'h8000_0000,0,        0,1,1,32'h13,0,0,32'h0,1);
    bi = 32'h13; bp = 32'h8000_0000;
    add(1,0,32'h8000_0004,1,        0,1,0,32'h0,0,0,32'h0,1);
    add(1,1,32'h8000_0004,0,        0,1,0,32'h0,0,0,32'h0,1);
    add(1,0,32'h8000_0004,0,        0,1,1,32'h13,0,0,32'h0,1);
    bp = 32'h8000_0004;
    add(1,0,32'h8000_0008,1,        0,1,0,32'h0,0,0,32'h0,1);
    add(1,1,32'h8000_0008,0,        0,1,0,32'h0,0,0,32'h0,1);
    add(1,0,32'h8000_0008,0,        0,1,1,32'h13,0,0,32'h0,1);
    bp = 32'h8000_0008;
    add(1,0,32'h8000_000C,1,        0,1,0,32'h0,0,0,32'h0,1);
    // memory not ready for 5 cycles, then decode stalls 4 cycles
    for (int k = 0; k < 5; k++) add(1,1,32'h8000_000C,0, 0,0,0,32'h0,0,0,32'h0,1);
    add(1,1,32'h8000_000C,0,        0,1,0,32'h0,0,0,32'h0,1);
    add(1,0,32'h8000_000C,0,        0,1,1,32'h93,0,0,32'h0,1);
    bi = 32'h93; bp = 32'h8000_000C;
    for (int k = 0; k < 4; k++) add(1,0,32'h8000_0010,1, 0,1,0,32'h0,0,0,32'h0,0);
    add(1,0,32'h8000_0010,1,        0,1,0,32'h0,0,0,32'h0,1);
    add(1,1,32'h8000_0010,0,        0,1,0,32'h0,0,0,32'h0,1);
    // redirect in WAIT, stale DEADBEEF arrives two cycles later
    add(1,0,32'h8000_0010,0,        0,0,0,32'h0,0,1,32'h8000_0100,1);
    add(1,0,32'h8000_0100,0,        0,0,0,32'h0,0,0,32'h0,1);
    add(1,0,32'h8000_0100,0,        0,0,1,32'hDEAD_BEEF,0,0,32'h0,1);
    add(1,1,32'h8000_0100,0,        0,1,0,32'h0,0,0,32'h0,1);
    add(1,0,32'h8000_0100,0,        0,1,1,32'h0010_0073,0,0,32'h0,1);
    bi = 32'h0010_0073; bp = 32'h8000_0100;
    add(1,0,32'h8000_0104,1,        0,1,0,32'h0,0,0,32'h0,1);
    // redirect coincident with the response
    add(1,1,32'h8000_0104,0,        0,1,0,32'h0,0,0,32'h0,1);
    add(1,0,32'h8000_0104,0,        0,1,1,32'h1111_1111,0,1,32'h8000_0200,1);
    add(1,1,32'h8000_0200,0,        0,1,0,32'h0,0,0,32'h0,1);
    add(1,0,32'h8000_0200,0,        0,1,1,32'h2222_2222,0,0,32'h0,1);
    bi = 32'h2222_2222; bp = 32'h8000_0200;
    // redirect in HOLD while decode stalls; then an error response
    add(1,0,32'h8000_0204,1,        0,1,0,32'h0,0,1,32'h8000_0008,0);
    add(1,1,32'h8000_0008,0,        0,1,0,32'h0,0,0,32'h0,1);
    add(1,0,32'h8000_0008,0,        0,1,1,32'hAAAA_AAAA,1,0,32'h0,1);
    bi = 32'h0; bp = 32'h8000_0008; bf = 1'b1;
    add(1,0,32'h8000_000C,1,        0,1,0,32'h0,0,0,32'h0,1);
    add(1,1,32'h8000_000C,0,        0,1,0,32'h0,0,0,32'h0,1);
    add(1,0,32'h8000_000C,0,        0,1,1,32'h3333_3333,0,0,32'h0,1);
    bi = 32'h3333_3333; bp = 32'h8000_000C; bf = 1'b0;
    // redirect with inst_ready in HOLD, to the top of the address space
    add(1,0,32'h8000_0010,1,        0,1,0,32'h0,0,1,32'hFFFF_FFFC,1);
    add(1,1,32'hFFFF_FFFC,0,        0,1,0,32'h0,0,0,32'h0,1);
    add(1,0,32'hFFFF_FFFC,0,        0,1,1,32'h4444_4444,0,0,32'h0,1);
    bi = 32'h4444_4444; bp = 32'hFFFF_FFFC;
    add(1,0,32'h0000_0000,1,        0,1,0,32'h0,0,0,32'h0,1);
    // redirect with request accepted, back-to-back redirect, stale response
    add(1,1,32'h0000_0000,0,        0,1,0,32'h0,0,1,32'h8000_0300,1);
    add(1,0,32'h8000_0300,0,        0,1,0,32'h0,0,1,32'h8000_0400,1);
    add(1,0,32'h8000_0400,0,        0,1,1,32'h5555_5555,0,0,32'h0,1);
    add(1,1,32'h8000_0400,0,        0,0,0,32'h0,0,1,32'h8000_0102,1);
`ifdef IFU32_MISALIGN_TRAP_EN
    add(1,0,32'h8000_0102,0,        0,1,0,32'h0,0,0,32'h0,0);
    bi = 32'h0; bp = 32'h8000_0102; bf = 1'b1;
    add(1,0,32'h8000_0102,1,        0,0,0,32'h0,0,1,32'h8000_0104,0);
    add(1,1,32'h8000_0104,0,        0,0,0,32'h0,0,0,32'h0,0);
    add(1,1,32'h8000_0104,0,        0,0,0,32'h0,0,0,32'h0,0);
`else
    add(1,1,32'h8000_0100,0,        0,1,0,32'h0,0,0,32'h0,0);
    add(1,0,32'h8000_0100,0,        0,1,1,32'h6666_6666,0,0,32'h0,0);
    bi = 32'h6666_6666; bp = 32'h8000_0100; bf = 1'b0;
    add(1,0,32'h8000_0104,1,        0,0,0,32'h0,0,0,32'h0,0);
    add(1,0,32'h8000_0104,1,        0,0,0,32'h0,0,0,32'h0,1);
`endif
    // reset mid-fetch; response for the abandoned request is ignored
    add(1,1,32'h8000_0104,0,        0,1,0,32'h0,0,0,32'h0,1);
    add(1,0,32'h8000_0104,0,        1,0,0,32'h0,0,0,32'h0,1);
    bi = 32'h0; bp = 32'h0; bf = 1'b0;
    add(1,0,32'h8000_0000,0,        0,0,1,32'h7777_7777,0,0,32'h0,1);
    add(1,1,32'h8000_0000,0,        0,1,0,32'h0,0,0,32'h0,1);
    add(1,0,32'h8000_0000,0,        0,1,1,32'h13,0,0,32'h0,1);
    bi = 32'h13; bp = 32'h8000_0000;
    add(1,0,32'h8000_0004,1,        0,0,0,32'h0,0,0,32'h0,1);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      if (vecs[i].chk) begin
        check($sformatf("row%0d req_valid", i),  {31'h0, imem_req_valid}, {31'h0, vecs[i].qv});
        check($sformatf("row%0d imem_addr", i),  imem_addr,               vecs[i].addr);
        check($sformatf("row%0d inst_valid", i), {31'h0, inst_valid},     {31'h0, vecs[i].iv});
        check($sformatf("row%0d inst", i),       inst,                    vecs[i].bi);
        check($sformatf("row%0d inst_pc", i),    inst_pc,                 vecs[i].bp);
        check($sformatf("row%0d inst_fault", i), {31'h0, inst_fault},     {31'h0, vecs[i].bf});
      end
      rst             = vecs[i].r;
      imem_req_ready  = vecs[i].rdy;
      imem_resp_valid = vecs[i].rv;
      imem_resp_data  = vecs[i].rd;
      imem_resp_err   = vecs[i].re;
      redirect_valid  = vecs[i].xv;
      redirect_pc     = vecs[i].xpc;
      inst_ready      = vecs[i].ir;
    end

    // 3-cycle memory latency: two extra WAIT cycles, word then held stable
    begin
      int cyc;
      cyc = 0;
      @(negedge clk);
      inst_ready = 1'b0;
      while (!imem_req_valid && cyc < 10) begin
        @(negedge clk);
        cyc++;
      end
      check("lat req seen", {31'h0, imem_req_valid}, 32'h1);
      check("lat req addr", imem_addr, 32'h8000_0004);
      imem_req_ready = 1'b1;
      @(negedge clk);
      imem_req_ready = 1'b0;
      for (int k = 0; k < 2; k++) begin
        check($sformatf("lat wait%0d inst_valid", k), {31'h0, inst_valid}, 32'h0);
        check($sformatf("lat wait%0d req_valid", k),  {31'h0, imem_req_valid}, 32'h0);
        @(negedge clk);
      end
      imem_resp_valid = 1'b1;
      imem_resp_data  = 32'h0000_0513;
      cyc = 0;
      @(negedge clk);
      imem_resp_valid = 1'b0;
      while (!inst_valid && cyc < 10) begin
        @(negedge clk);
        cyc++;
      end
      check("lat hold delay", cyc, 32'd0);
      for (int k = 0; k < 3; k++) begin
        check($sformatf("lat hold%0d inst_valid", k), {31'h0, inst_valid}, 32'h1);
        check($sformatf("lat hold%0d inst", k),       inst,    32'h0000_0513);
        check($sformatf("lat hold%0d inst_pc", k),    inst_pc, 32'h8000_0004);
        check($sformatf("lat hold%0d addr", k),       imem_addr, 32'h8000_0008);
        @(negedge clk);
      end
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
